serpent_key_schedule_param: RTL and testbench
=============================================

# serpent_key_schedule_param

Parametrised Serpent key-expansion engine that turns a 128/192/256-bit user key into the 33 × 128-bit round subkeys. Subkeys are streamed out in address order over a valid/ready handshake with backpressure. The block feeds the subkey store of the XTS cipher cores. It is the successor to the fixed 256-bit, one-word-per-cycle key schedule: it adds selectable key length, configurable prekey throughput, input/output handshakes and a completion pulse.

## Interface

- `WORDS_PER_CYCLE`, default 1: prekey words generated per clock.
  - Legal values are 1, 2 and 4.
  - Any other value is an elaboration `$error`.
- `i_clk` input 1: clock; all logic is on the rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_key_valid` input 1: key request.
- `o_key_ready` output 1: high only in IDLE.
- `i_key` input 256: user key; 32-bit word k is `i_key[32k+31:32k]`.
- `i_key_len` input 2: key length select.
  - 00: 128-bit key.
  - 01: 192-bit key.
  - 10 and 11: 256-bit key.
- `o_subkey` output 128: subkey, packed as {K3,K2,K1,K0} bitsliced words.
- `o_address` output 6: subkey index, 0..32.
- `o_subkey_valid` output 1: subkey present on `o_subkey`/`o_address`.
- `i_subkey_ready` input 1: downstream accepts the subkey.
- `o_busy` output 1: high from key acceptance until the `o_done` pulse.
- `o_done` output 1: one-cycle pulse after subkey 32 is transferred.

## Operation

- **Key acceptance:** a key is accepted when `i_key_valid && o_key_ready`.
  - `i_key` and `i_key_len` are sampled on that edge.
  - `i_key_valid` is ignored while busy.
- **Key padding:** keys shorter than 256 bits are padded.
  - Bit L is set to 1, where L is 128 or 192.
  - All bits above L are cleared.
  - The padded key forms the initial 8-word window w₋₈..w₋₁, with w₋₈ = word 0.
- **Prekey recurrence:** w_i = ROL32(w_{i-8} ^ w_{i-5} ^ w_{i-3} ^ w_{i-1} ^ 0x9E3779B9 ^ i, 11), for i = 0..131.
  - i is a 32-bit value zero-extended from an 8-bit counter.
  - `WORDS_PER_CYCLE` words are chained combinationally per cycle.
  - The window shifts by `WORDS_PER_CYCLE` each advancing cycle.
- **Subkey formation:** subkey j = S_{(3−j) mod 8} applied bitsliced to w_{4j}..w_{4j+3}.
  - The S-box output is written into the output register.
  - `o_address` is set to j.
- **State machine:**
  - IDLE → GEN on key acceptance.
  - GEN → DRAIN once subkey 32 is loaded into the output register.
  - DRAIN → DONE when subkey 32 is transferred.
  - DONE → IDLE unconditionally after one cycle. `o_done` = 1 in DONE.
- **Backpressure:** a single output register holds the subkey.
  - Generation advances in a cycle only if a new word group does not complete a subkey, or the output register is empty, or the output register is transferred in the same cycle.
  - When generation does not advance, the window and counters hold.
- **Handshake rules:**
  - While `o_subkey_valid` is high, `o_subkey` and `o_address` are stable until transferred.
  - Transfer occurs when `o_subkey_valid && i_subkey_ready`.
- **Reset:** `i_rst`, including mid-schedule, returns the block to IDLE on the next edge.
  - The window, counters and output register are cleared.
  - The next key starts cleanly.
- **Reset values:**
  - `o_key_ready` = 1.
  - `o_subkey` = 0, `o_address` = 0.
  - `o_subkey_valid` = 0, `o_busy` = 0, `o_done` = 0.

## Timing

- Key accepted at edge E0, with no stall: subkey j is valid after edge E0 + (j+1)·4/`WORDS_PER_CYCLE`.
- `WORDS_PER_CYCLE` = 1: subkey 0 after E4, subkey 32 after E132.
- `WORDS_PER_CYCLE` = 4: subkey 0 after E1, then one subkey per cycle; subkey 32 after E33.
- `o_done` is high in the cycle after the subkey-32 transfer edge.
- `o_key_ready` rises in the cycle after `o_done`; a new key can be accepted on that cycle's edge.
- A stall of N cycles delays all later subkeys by exactly N cycles.
- `o_busy` falls together with `o_key_ready` rising.

## Configuration

- Macro: `SERPENT_KS_KEYLEN_EN`.
- Defined: 128/192/256-bit keys are supported as described above.
- Undefined:
  - The padding logic is removed and `i_key_len` is ignored.
  - Every key is treated as 256-bit.
  - The port remains present.

## Structure

- Package `serpent_pkg`:
  - `SERPENT_PHI` = 32'h9E3779B9.
  - `SERPENT_NUM_SUBKEYS` = 33.
  - `SERPENT_NUM_PREKEYS` = 132.
  - The `key_len_t` enum.
  - The FSM state enum.
- Sub-module `serpent_sbox_bitslice`:
  - Combinational.
  - Input: 3-bit S-box index plus 4 × 32-bit words.
  - Output: 4 × 32-bit words.
  - Shared with the cipher round logic.

## Test plan

- **256-bit all-zero key, `WORDS_PER_CYCLE` = 1, ready held high:**
  - Internal w_0 = 32'hBBCDCCF1.
  - Addresses 0..32 appear in order.
  - Subkey 0 is valid after E4.
  - All 33 subkeys match the C golden model.
  - One `o_done` pulse.
- **Key length 00 and 01 with key 00112233…eeff, `WORDS_PER_CYCLE` = 4:**
  - Subkeys match the golden model with the 1-bit pad at bit 128 and at bit 192.
  - Subkey 0 is valid after E1; subkey 32 is valid after E33.
  - Key length 11 gives the same result as key length 10.
- **Random `i_subkey_ready` backpressure at 30%, `WORDS_PER_CYCLE` = 2:**
  - Data and address hold while stalled.
  - No subkey is dropped or duplicated.
  - The subkey sequence is identical to the no-stall run.
- **`i_rst` pulsed while address 10 is valid:**
  - All outputs are 0 and `o_key_ready` = 1 on the next cycle.
  - A fresh key then produces the full correct 33-subkey sequence.
- **`i_key_valid` held high throughout a schedule:**
  - Only one key is accepted per schedule.
  - The next acceptance occurs in the cycle after `o_done`.
- **Build without `SERPENT_KS_KEYLEN_EN`:**
  - `i_key_len` = 00 produces the 256-bit schedule of the full `i_key`.

Source files
------------

// File: rtl/serpent_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serpent_pkg
// Brief    : Shared constants, enums and S-box lookup for the Serpent key
//            schedule and cipher round logic.
// Revision : 1.0
// ============================================================================
package serpent_pkg;

    localparam logic [31:0] SERPENT_PHI         = 32'h9E3779B9;
    localparam int          SERPENT_NUM_SUBKEYS = 33;
    localparam int          SERPENT_NUM_PREKEYS = 132;

    typedef enum logic [1:0] {
        KEY_LEN_128     = 2'b00,
        KEY_LEN_192     = 2'b01,
        KEY_LEN_256     = 2'b10,
        KEY_LEN_256_ALT = 2'b11
    } key_len_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ks_state_t;

    // Row s holds S-box s; entry x occupies bits [4x+3:4x].
    localparam logic [7:0][63:0] c_sbox = {
        64'h6539AC47B28E0FD1,
        64'h0A3DF19EB6485C27,
        64'h176D8E30C9A4B25F,
        64'hD7E9A4526B0C38F1,
        64'hE57A421D369C8BF0,
        64'h25B04E1DFAC39768,
        64'h43D68EB1A50972CF,
        64'hC90724DEB56A1F83
    };

    function automatic logic [3:0] sbox_nibble(input logic [2:0] sel, input logic [3:0] x);
        logic [63:0] row;
        row = c_sbox[sel];
        return row[{x, 2'b00} +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/serpent_sbox_bitslice.sv
`default_nettype none
// ============================================================================
// Module   : serpent_sbox_bitslice
// Brief    : Combinational bitsliced Serpent S-box; bit b of the four input
//            words forms one nibble (word 0 is the LSB).
// Revision : 1.0
// ============================================================================
module serpent_sbox_bitslice
    import serpent_pkg::*;
(
    input  logic [2:0]  i_sel,
    input  logic [31:0] i_x0,
    input  logic [31:0] i_x1,
    input  logic [31:0] i_x2,
    input  logic [31:0] i_x3,
    output logic [31:0] o_y0,
    output logic [31:0] o_y1,
    output logic [31:0] o_y2,
    output logic [31:0] o_y3
);

    for (genvar b = 0; b < 32; b++) begin : g_bit
        logic [3:0] w_out;
        assign w_out   = sbox_nibble(i_sel, {i_x3[b], i_x2[b], i_x1[b], i_x0[b]});
        assign o_y0[b] = w_out[0];
        assign o_y1[b] = w_out[1];
        assign o_y2[b] = w_out[2];
        assign o_y3[b] = w_out[3];
    end

endmodule
`default_nettype wire

// File: rtl/serpent_key_schedule_param.sv
`default_nettype none
// ============================================================================
// Module   : serpent_key_schedule_param
// Brief    : Serpent key expansion, 128/192/256-bit keys to 33 streamed
//            subkeys with valid/ready backpressure. Key-length padding is
//            built only when SERPENT_KS_KEYLEN_EN is defined.
// Revision : 1.0
// ============================================================================
module serpent_key_schedule_param
    import serpent_pkg::*;
#(
    parameter int WORDS_PER_CYCLE = 1
)
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_key_valid,
    output logic         o_key_ready,
    input  logic [255:0] i_key,
    input  logic [1:0]   i_key_len,
    output logic [127:0] o_subkey,
    output logic [5:0]   o_address,
    output logic         o_subkey_valid,
    input  logic         i_subkey_ready,
    output logic         o_busy,
    output logic         o_done
);

    if (!(WORDS_PER_CYCLE == 1 || WORDS_PER_CYCLE == 2 || WORDS_PER_CYCLE == 4)) begin : g_bad_wpc
        $error("serpent_key_schedule_param: WORDS_PER_CYCLE must be 1, 2 or 4");
    end

    ks_state_t    r_state;
    ks_state_t    w_state_next;

    logic [31:0]  r_win [0:7];
    logic [7:0]   r_idx;
    logic [127:0] r_subkey;
    logic [5:0]   r_address;
    logic         r_valid;

    logic [255:0] w_padded;
    logic [31:0]  w_ext [0:7+WORDS_PER_CYCLE];
    logic [31:0]  w_t;
    logic [7:0]   w_last_idx;
    logic [5:0]   w_sk_idx;
    logic [2:0]   w_sbox_sel;
    logic         w_accept;
    logic         w_xfer;
    logic         w_completes;
    logic         w_advance;
    logic         w_load;
    logic         w_last_subkey;
    logic [31:0]  w_y0;
    logic [31:0]  w_y1;
    logic [31:0]  w_y2;
    logic [31:0]  w_y3;

`ifdef SERPENT_KS_KEYLEN_EN
    always_comb begin
        case (key_len_t'(i_key_len))
            KEY_LEN_128: w_padded = {127'd0, 1'b1, i_key[127:0]};
            KEY_LEN_192: w_padded = {63'd0, 1'b1, i_key[191:0]};
            default:     w_padded = i_key;
        endcase
    end
`else
    logic w_unused_key_len;
    assign w_padded         = i_key;
    assign w_unused_key_len = ^i_key_len;
`endif

    // Window occupies w_ext[0..7]; the new prekeys are chained after it.
    always_comb begin
        w_t = '0;
        for (int k = 0; k < 8; k++) begin
            w_ext[k] = r_win[k];
        end
        for (int k = 0; k < WORDS_PER_CYCLE; k++) begin
            w_t = w_ext[k] ^ w_ext[k+3] ^ w_ext[k+5] ^ w_ext[k+7] ^ SERPENT_PHI
                ^ {24'd0, r_idx + 8'(k)};
            w_ext[8+k] = {w_t[20:0], w_t[31:21]};
        end
    end

    // Groups are aligned to 4, so a group completes a subkey when its last
    // word lands on an index of the form 4j+3.
    assign w_last_idx    = r_idx + 8'(WORDS_PER_CYCLE - 1);
    assign w_completes   = (w_last_idx[1:0] == 2'b11);
    assign w_sk_idx      = w_last_idx[7:2];
    assign w_sbox_sel    = 3'd3 - w_sk_idx[2:0];
    assign w_last_subkey = (w_sk_idx == 6'(SERPENT_NUM_SUBKEYS - 1));

    assign w_xfer    = r_valid && i_subkey_ready;
    assign w_accept  = i_key_valid && (r_state == ST_IDLE);
    assign w_advance = (r_state == ST_GEN) && (!w_completes || !r_valid || w_xfer);
    assign w_load    = w_advance && w_completes;

    serpent_sbox_bitslice u_sbox (
        .i_sel (w_sbox_sel),
        .i_x0  (w_ext[WORDS_PER_CYCLE + 4]),
        .i_x1  (w_ext[WORDS_PER_CYCLE + 5]),
        .i_x2  (w_ext[WORDS_PER_CYCLE + 6]),
        .i_x3  (w_ext[WORDS_PER_CYCLE + 7]),
        .o_y0  (w_y0),
        .o_y1  (w_y1),
        .o_y2  (w_y2),
        .o_y3  (w_y3)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_key_valid)             w_state_next = ST_GEN;
            ST_GEN:   if (w_load && w_last_subkey) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_xfer)                  w_state_next = ST_DONE;
            ST_DONE:                               w_state_next = ST_IDLE;
            default:                               w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < 8; k++) begin
                r_win[k] <= '0;
            end
            r_idx     <= '0;
            r_subkey  <= '0;
            r_address <= '0;
            r_valid   <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int k = 0; k < 8; k++) begin
                    r_win[k] <= w_padded[32*k +: 32];
                end
                r_idx <= '0;
            end else if (w_advance) begin
                for (int k = 0; k < 8; k++) begin
                    r_win[k] <= w_ext[k + WORDS_PER_CYCLE];
                end
                r_idx <= r_idx + 8'(WORDS_PER_CYCLE);
            end

            if (w_load) begin
                r_subkey  <= {w_y3, w_y2, w_y1, w_y0};
                r_address <= w_sk_idx;
                r_valid   <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_key_ready    = (r_state == ST_IDLE);
    assign o_busy         = (r_state != ST_IDLE);
    assign o_done         = (r_state == ST_DONE);
    assign o_subkey       = r_subkey;
    assign o_address      = r_address;
    assign o_subkey_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_serpent_key_schedule_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_serpent_key_schedule_param
// Brief    : Self-checking bench; three DUTs (1, 2 and 4 words per cycle)
//            checked against a behavioural Serpent key-schedule model.
// Revision : 1.0
// ============================================================================
module tb_serpent_key_schedule_param;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] key;
    logic [1:0]   key_len;
    logic         kv   [3];
    logic         kr   [3];
    logic         sv   [3];
    logic         sr   [3];
    logic         busy [3];
    logic         done [3];
    logic [127:0] sk   [3];
    logic [5:0]   ad   [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_sk [33];
    logic [31:0]  model_w0;

    int SB [8][16] = '{
        '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
        '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
        '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
        '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
        '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
        '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
        '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
        '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
    };

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        serpent_key_schedule_param #(
            .WORDS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))
        ) u_dut (
            .i_clk          (clk),
            .i_rst          (rst),
            .i_key_valid    (kv[g]),
            .o_key_ready    (kr[g]),
            .i_key          (key),
            .i_key_len      (key_len),
            .o_subkey       (sk[g]),
            .o_address      (ad[g]),
            .o_subkey_valid (sv[g]),
            .i_subkey_ready (sr[g]),
            .o_busy         (busy[g]),
            .o_done         (done[g])
        );
    end

    function automatic int wpc_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic build_model(input logic [255:0] k_in, input logic [1:0] len);
        logic [255:0] k;
        logic [31:0]  w [140];
        logic [31:0]  t;
        int s, x, y;
        k = k_in;
`ifdef SERPENT_KS_KEYLEN_EN
        if (len == 2'b00) begin
            k[255:128] = '0;
            k[128]     = 1'b1;
        end else if (len == 2'b01) begin
            k[255:192] = '0;
            k[192]     = 1'b1;
        end
`else
        if (len === 2'bzz) k = '0;
`endif
        for (int i = 0; i < 8; i++) w[i] = k[32*i +: 32];
        for (int i = 0; i < 132; i++) begin
            t = w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7] ^ 32'h9E3779B9 ^ 32'(i);
            w[i+8] = (t << 11) | (t >> 21);
        end
        model_w0 = w[8];
        for (int j = 0; j < 33; j++) begin
            s = (((3 - j) % 8) + 8) % 8;
            for (int b = 0; b < 32; b++) begin
                x = int'(w[8+4*j][b]) + 2 * int'(w[9+4*j][b])
                  + 4 * int'(w[10+4*j][b]) + 8 * int'(w[11+4*j][b]);
                y = SB[s][x];
                for (int q = 0; q < 4; q++) exp_sk[j][32*q+b] = 1'((y >> q) & 1);
            end
        end
    endtask

    // Runs one full schedule on DUT d and checks every transferred subkey.
    task automatic run_key(input int d, input logic [255:0] k_in, input logic [1:0] len,
                           input int stall_pct, input bit chk_timing, input bit hold_valid,
                           input string name);
        int n, got;
        bit stalled, ready;
        logic [127:0] held_sk;
        logic [5:0]   held_ad;
        build_model(k_in, len);
        @(negedge clk);
        key = k_in; key_len = len;
        n_checks++;
        if (kr[d] !== 1'b1) begin
            n_fail++; $display("FAIL %s key_ready_at_start: got %b expected 1", name, kr[d]);
        end
        kv[d] = 1'b1;
        @(posedge clk);
        n = 0; got = 0; stalled = 0; held_sk = '0; held_ad = '0;
        while (got < 33 && n < 3000) begin
            @(negedge clk);
            if (!hold_valid) kv[d] = 1'b0;
            n_checks++;
            if (kr[d] !== 1'b0 || busy[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy_during_run: got ready=%b busy=%b expected ready=0 busy=1", name, kr[d], busy[d]);
            end
            if (stalled) begin
                n_checks++;
                if (sv[d] !== 1'b1 || sk[d] !== held_sk || ad[d] !== held_ad) begin
                    n_fail++;
                    $display("FAIL %s hold_while_stalled: got v=%b a=%0d d=%h expected v=1 a=%0d d=%h",
                             name, sv[d], ad[d], sk[d], held_ad, held_sk);
                end
            end
            ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= 32'(stall_pct));
            sr[d] = ready;
            if (sv[d] === 1'b1) begin
                if (ready) begin
                    n_checks++;
                    if (ad[d] !== 6'(got)) begin
                        n_fail++; $display("FAIL %s address: got %0d expected %0d", name, ad[d], got);
                    end
                    n_checks++;
                    if (sk[d] !== exp_sk[got]) begin
                        n_fail++; $display("FAIL %s subkey[%0d]: got %h expected %h", name, got, sk[d], exp_sk[got]);
                    end
                    if (chk_timing) begin
                        n_checks++;
                        if (n != (got + 1) * 4 / wpc_of(d)) begin
                            n_fail++;
                            $display("FAIL %s timing[%0d]: got edge %0d expected edge %0d", name, got, n, (got + 1) * 4 / wpc_of(d));
                        end
                    end
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1; held_sk = sk[d]; held_ad = ad[d];
                end
            end
            @(posedge clk);
            n++;
        end
        n_checks++;
        if (got < 33) begin
            n_fail++; $display("FAIL %s timeout: got %0d subkeys expected 33", name, got);
        end else begin
            @(negedge clk);
            n_checks++;
            if (done[d] !== 1'b1 || busy[d] !== 1'b1 || sv[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done_pulse: got done=%b busy=%b valid=%b expected 1 1 0", name, done[d], busy[d], sv[d]);
            end
            @(negedge clk);
            n_checks++;
            if (done[d] !== 1'b0 || kr[d] !== 1'b1 || busy[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s after_done: got done=%b ready=%b busy=%b expected 0 1 0", name, done[d], kr[d], busy[d]);
            end
            if (hold_valid) begin
                @(posedge clk);
                @(negedge clk);
                kv[d] = 1'b0;
                n_checks++;
                if (busy[d] !== 1'b1 || kr[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s reaccept: got busy=%b ready=%b expected 1 0", name, busy[d], kr[d]);
                end
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; key = '0; key_len = 2'b10;
        for (int d = 0; d < 3; d++) begin kv[d] = 1'b0; sr[d] = 1'b1; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (sk[d] !== '0 || ad[d] !== '0 || sv[d] !== 1'b0 || busy[d] !== 1'b0
                || done[d] !== 1'b0 || kr[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got sk=%h a=%0d v=%b busy=%b done=%b ready=%b expected zeros and ready=1",
                         d, sk[d], ad[d], sv[d], busy[d], done[d], kr[d]);
            end
        end
    endtask

    task automatic test_zero_key();
        build_model('0, 2'b10);
        n_checks++;
        if (model_w0 !== 32'hBBCDCCF1) begin
            n_fail++; $display("FAIL model_w0: got %h expected bbcdccf1", model_w0);
        end
        run_key(0, '0, 2'b10, 0, 1'b1, 1'b0, "zero_key_wpc1");
    endtask

    task automatic test_keylen();
        logic [255:0] k;
        k = 256'h00112233_44556677_8899aabb_ccddeeff_00112233_44556677_8899aabb_ccddeeff;
        run_key(2, k, 2'b00, 0, 1'b1, 1'b0, "len128_wpc4");
        run_key(2, k, 2'b01, 0, 1'b1, 1'b0, "len192_wpc4");
        run_key(2, k, 2'b10, 0, 1'b1, 1'b0, "len256_wpc4");
        run_key(2, k, 2'b11, 0, 1'b1, 1'b0, "len256alt_wpc4");
    endtask

    task automatic test_backpressure();
        run_key(1, rand_key(), 2'($urandom_range(0, 3)), 30, 1'b0, 1'b0, "stall_wpc2_a");
        run_key(1, rand_key(), 2'b10, 30, 1'b0, 1'b0, "stall_wpc2_b");
        run_key(2, rand_key(), 2'b01, 30, 1'b0, 1'b0, "stall_wpc4");
    endtask

    task automatic test_random_keys();
        for (int d = 0; d < 3; d++) begin
            run_key(d, rand_key(), 2'($urandom_range(0, 3)), 0, 1'b1, 1'b0, "random_key");
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 0;
        @(negedge clk);
        key = rand_key(); key_len = 2'b10; kv[0] = 1'b1; sr[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kv[0] = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (sv[0] === 1'b1 && ad[0] === 6'd10) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL reset_mid_wait: got no address 10 expected address 10 valid");
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (sk[0] !== '0 || ad[0] !== '0 || sv[0] !== 1'b0 || busy[0] !== 1'b0
            || done[0] !== 1'b0 || kr[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_state: got sk=%h a=%0d v=%b busy=%b done=%b ready=%b expected zeros and ready=1",
                     sk[0], ad[0], sv[0], busy[0], done[0], kr[0]);
        end
        run_key(0, rand_key(), 2'b10, 0, 1'b1, 1'b0, "after_reset_wpc1");
    endtask

    task automatic test_hold_valid();
        run_key(2, rand_key(), 2'b10, 0, 1'b1, 1'b1, "hold_valid_wpc4");
        pulse_reset();
    endtask

    initial begin
        test_reset();
        test_zero_key();
        test_keylen();
        test_random_keys();
        test_backpressure();
        test_reset_mid();
        test_hold_valid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
